dm_arbiter: RTL

Two-port arbiter and access sequencer for the byte-addressed data memory (DM, 128 bytes, big-endian word access, registered read). Sits between the CPU load/store port (port 0) and a debug/loader port (port 1), serialises their word accesses onto DM's single MemAddr/MemWriteData/MemWrite/MemRead interface, and returns read data and a per-access done/error response. Out-of-range or misaligned requests are rejected without touching DM.

---
 rtl/dm_arb_pkg.sv | 20 ++
 rtl/dm_arb_rr2.sv | 36 +++
 rtl/dm_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// The address legality check lives here so that the arbiter and any future requester use the same rule.
package dm_arb_pkg;

  localparam int unsigned MEM_SIZE   = 128;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // The upper bound is a full-width unsigned compare, so high address bits can never alias into the array.
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input logic [31:0] mem_size = 32'(MEM_SIZE));
    return (addr[1:0] == 2'b00) && (addr <= mem_size - 32'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/dm_arb_rr2.sv
// Two-way round-robin picker. It owns the last-grant pointer, which resets to 1 so that port 0 wins the first tie.
module dm_arb_rr2
  import dm_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       last,        // commit the current grant into the last-grant pointer
  output logic       grant_valid,
  output logic       grant_id
);

  logic r_ptr;

  // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    grant_valid = |req;
    grant_id    = 1'b0;
    case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~r_ptr;
      default: grant_id = 1'b0;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= 1'b1;
    end else if (last && grant_valid) begin
      r_ptr <= grant_id;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Arbiter and access sequencer that serialises CPU (port 0) and debug (port 1) word accesses onto the DM port.
// Illegal requests are answered with an error and never touch DM; the DM controls are driven only from flops.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned MEM_SIZE = dm_arb_pkg::MEM_SIZE,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  output logic              ack0,
  output logic              err0,
  output logic [31:0]       rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  output logic              ack1,
  output logic              err1,
  output logic [31:0]       rdata1,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [31:0]       MemReadData
);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_grant_valid;
  logic              w_grant_id;
  logic              w_take;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic              w_legal;
  logic [31:0]       w_rdata;

  logic              r_id;
  logic              r_we;
  logic              r_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_mem_write;
  logic              r_mem_read;

  assign w_take = (r_state == IDLE) && w_grant_valid;

  dm_arb_rr2 u_rr2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         ({req1, req0}),
    .last        (w_take),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  assign w_sel_we    = w_grant_id ? we1    : we0;
  assign w_sel_addr  = w_grant_id ? addr1  : addr0;
  assign w_sel_wdata = w_grant_id ? wdata1 : wdata0;
  assign w_legal     = addr_ok(32'(w_sel_addr), 32'(MEM_SIZE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_next_state = w_legal ? ACCESS : RESP;
      ACCESS:  w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request latch and DM control registers; MemAddr/MemWriteData keep their value after the access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_id        <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (w_take) begin
      r_id  <= w_grant_id;
      r_we  <= w_sel_we;
      r_err <= ~w_legal;
      if (w_legal) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
        r_mem_write <= w_sel_we;
        r_mem_read  <= ~w_sel_we;
      end
    end else if (r_state == ACCESS) begin
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end
  end

  assign MemAddr      = r_mem_addr;
  assign MemWriteData = r_mem_wdata;
  assign MemWrite     = r_mem_write;
  assign MemRead      = r_mem_read;

  always_comb begin
    ack0    = 1'b0;
    err0    = 1'b0;
    rdata0  = '0;
    ack1    = 1'b0;
    err1    = 1'b0;
    rdata1  = '0;
    w_rdata = (!r_err && !r_we) ? MemReadData : 32'h0;
    if (r_state == RESP) begin
      if (r_id) begin
        ack1   = 1'b1;
        err1   = r_err;
        rdata1 = w_rdata;
      end else begin
        ack0   = 1'b1;
        err0   = r_err;
        rdata0 = w_rdata;
      end
    end
  end

endmodule
